// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: queues target words and pulses J/K so an external
// JK flip-flop bank steps through them, then checks the bank's feedback.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   in_valid  target word offered
//   in_data   target word (WIDTH bits)
//   in_ready  FIFO can accept; low while in reset
//   q_fb      Q outputs of the external flip-flop bank
//   clr_err   synchronous clear of err / err_cnt
//   j, k      registered excitation to the flip-flop bank
//   done      one-cycle pulse when a target has been checked
//   match     q_fb equalled the target at the last done
//   err       sticky mismatch flag
//   err_cnt   saturating mismatch count
//   busy      FSM active or FIFO holding words
module jk_excitation_driver #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter bit TOGGLE_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [WIDTH-1:0] q_fb,
    input  logic             clr_err,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             match,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_done;
    logic             r_match;
    logic             r_err;
    logic [7:0]       r_err_cnt;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_jx;
    logic [WIDTH-1:0] w_kx;
    logic             w_miss;

    // Extra wrap bit: equal pointers mean empty, differing only in
    // the wrap bit means full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign in_ready = rst && !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty &&
                      (r_state == S_IDLE || r_state == S_CHECK);
    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

    // Bits that must change get set/reset, or a toggle in toggle mode.
    assign w_diff = w_head ^ q_fb;
    assign w_jx   = TOGGLE_MODE ? w_diff : (w_head & ~q_fb);
    assign w_kx   = TOGGLE_MODE ? w_diff : (~w_head & q_fb);

    assign w_miss = (q_fb != r_target);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_target  <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_done    <= 1'b0;
            r_match   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (clr_err) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_target <= w_head;
                        r_j      <= w_jx;
                        r_k      <= w_kx;
                        r_state  <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    r_done  <= 1'b1;
                    r_match <= !w_miss;
                    if (w_miss) begin
                        r_err <= 1'b1;
                        // A coincident clear wins first, leaving this miss.
                        if (clr_err) begin
                            r_err_cnt <= 8'd1;
                        end else if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                    end
                    if (!w_empty) begin
                        r_target <= w_head;
                        r_j      <= w_jx;
                        r_k      <= w_kx;
                        r_state  <= S_DRIVE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign j       = r_j;
    assign k       = r_k;
    assign done    = r_done;
    assign match   = r_match;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;
    assign busy    = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb_jk_excitation_driver: drives set/reset and toggle variants of
// jk_excitation_driver from one stimulus stream against a queue model.
module tb_jk_excitation_driver;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         clr_err = 1'b0;
    bit           ign = 1'b0;

    logic [W-1:0] bank0 = '0;
    logic [W-1:0] bank1 = '0;

    logic         in_ready0, in_ready1;
    logic [W-1:0] j0, k0, j1, k1;
    logic         done0, done1, match0, match1;
    logic         err0, err1, busy0, busy1;
    logic [7:0]   err_cnt0, err_cnt1;

    always #5 clk = ~clk;

    jk_excitation_driver #(
        .WIDTH(W), .DEPTH(D), .TOGGLE_MODE(1'b0)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .q_fb(bank0),
        .clr_err(clr_err), .j(j0), .k(k0),
        .done(done0), .match(match0), .err(err0),
        .err_cnt(err_cnt0), .busy(busy0)
    );

    jk_excitation_driver #(
        .WIDTH(W), .DEPTH(D), .TOGGLE_MODE(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .q_fb(bank1),
        .clr_err(clr_err), .j(j1), .k(k1),
        .done(done1), .match(match1), .err(err1),
        .err_cnt(err_cnt1), .busy(busy1)
    );

    // External JK bank; bit 0 can be made to ignore its inputs.
    function automatic logic [W-1:0] jk_next(
        input logic [W-1:0] q, input logic [W-1:0] jj,
        input logic [W-1:0] kk, input bit hold0);
        logic [W-1:0] n;
        n = (jj & ~q) | (~kk & q);
        if (hold0) n[0] = q[0];
        return n;
    endfunction

    always @(posedge clk) begin
        bank0 <= jk_next(bank0, j0, k0, ign);
        bank1 <= jk_next(bank1, j1, k1, ign);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: each accepted word is scheduled to a drive cycle.
    typedef struct {
        logic [W-1:0] d;
        int           drv;
    } ent_t;

    ent_t         fq[$];
    int           cyc = 0;
    int           last_drv = -10;
    logic [W-1:0] mq = '0;
    bit           m_err = 1'b0;
    int           m_cnt = 0;
    bit           m_match = 1'b0;

    task automatic excite(input logic [W-1:0] q,
                          input logic [W-1:0] t,
                          input bit tog,
                          output logic [W-1:0] jj,
                          output logic [W-1:0] kk);
        jj = '0;
        kk = '0;
        for (int i = 0; i < W; i++) begin
            if (q[i] != t[i]) begin
                if (tog) begin
                    jj[i] = 1'b1;
                    kk[i] = 1'b1;
                end else if (t[i]) begin
                    jj[i] = 1'b1;
                end else begin
                    kk[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        int           occ;
        int           nd;
        bit           rdy, pushok, e_done, miss;
        logic [W-1:0] ej0, ek0, ej1, ek1;
        @(negedge clk);
        occ = 0;
        foreach (fq[i]) if (fq[i].drv > cyc) occ++;
        rdy = rst && (occ < D);
        check("in_ready0", 32'(in_ready0), 32'(rdy));
        check("in_ready1", 32'(in_ready1), 32'(rdy));
        pushok = in_valid && rdy;
        @(posedge clk);
        cyc++;
        e_done = 1'b0;
        miss = 1'b0;
        ej0 = '0; ek0 = '0; ej1 = '0; ek1 = '0;
        if (rst) begin
            if (fq.size() > 0 && fq[0].drv + 2 == cyc) begin
                e_done = 1'b1;
                miss = (mq != fq[0].d);
                m_match = !miss;
                fq.delete(0);
            end
            if (clr_err) begin
                m_err = miss;
                m_cnt = miss ? 1 : 0;
            end else if (miss) begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            foreach (fq[i]) begin
                if (fq[i].drv == cyc) begin
                    excite(mq, fq[i].d, 1'b0, ej0, ek0);
                    excite(mq, fq[i].d, 1'b1, ej1, ek1);
                end
                if (fq[i].drv == cyc - 1) begin
                    mq = ign ? {fq[i].d[W-1:1], mq[0]} : fq[i].d;
                end
            end
            if (pushok) begin
                nd = (cyc + 1 > last_drv + 2) ? cyc + 1 : last_drv + 2;
                fq.push_back('{d: in_data, drv: nd});
                last_drv = nd;
            end
        end
        #1;
        check("j0", 32'(j0), 32'(ej0));
        check("k0", 32'(k0), 32'(ek0));
        check("j1", 32'(j1), 32'(ej1));
        check("k1", 32'(k1), 32'(ek1));
        check("done0", 32'(done0), 32'(e_done));
        check("done1", 32'(done1), 32'(e_done));
        check("match0", 32'(match0), 32'(m_match));
        check("match1", 32'(match1), 32'(m_match));
        check("err0", 32'(err0), 32'(m_err));
        check("err1", 32'(err1), 32'(m_err));
        check("cnt0", 32'(err_cnt0), 32'(m_cnt));
        check("cnt1", 32'(err_cnt1), 32'(m_cnt));
        check("busy0", 32'(busy0), 32'(fq.size() != 0));
        check("busy1", 32'(busy1), 32'(fq.size() != 0));
        check("bank0", 32'(bank0), 32'(mq));
        check("bank1", 32'(bank1), 32'(mq));
    endtask

    task automatic push_word(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (2 * D + 6) step();
        check("drained", 32'(fq.size()), 32'd0);
    endtask

    task automatic mid_reset();
        rst = 1'b0;
        #1;
        check("rst_j0", 32'(j0), 32'd0);
        check("rst_k0", 32'(k0), 32'd0);
        check("rst_j1", 32'(j1), 32'd0);
        check("rst_k1", 32'(k1), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_rdy", 32'(in_ready0), 32'd0);
        fq.delete();
        last_drv = -10;
        m_err = 1'b0;
        m_cnt = 0;
        m_match = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        check("init_rdy", 32'(in_ready0), 32'd0);
        check("init_j", 32'(j0), 32'd0);
        check("init_done", 32'(done0), 32'd0);
        check("init_cnt", 32'(err_cnt1), 32'd0);
        step();
        step();
        rst = 1'b1;
        repeat (10) step();

        // Set/reset steps from 0000, then back-to-back word.
        push_word(4'b1010);
        push_word(4'b0110);
        check("d_j1010", 32'(j0), 32'(4'b1010));
        check("d_k1010", 32'(k0), 32'(4'b0000));
        step();
        step();
        check("d_done", 32'(done0), 32'd1);
        check("d_match", 32'(match0), 32'd1);
        check("d_j0110", 32'(j0), 32'(4'b0100));
        check("d_k0110", 32'(k0), 32'(4'b1000));
        drain();

        // Toggle variant from 0011 to 0101.
        push_word(4'b0011);
        drain();
        push_word(4'b0101);
        step();
        check("t_j", 32'(j1), 32'(4'b0110));
        check("t_k", 32'(k1), 32'(4'b0110));
        drain();

        // Target equal to current Q.
        push_word(4'b0101);
        step();
        check("h_j", 32'(j0), 32'd0);
        drain();

        // Continuous offers fill the FIFO and stall in_ready.
        in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_data = W'(i * 5 + 3);
            step();
        end
        in_valid = 1'b0;
        drain();

        // Reset in the DRIVE cycle.
        push_word(~mq);
        step();
        mid_reset();
        repeat (6) step();

        // Saturating mismatch count with bit 0 stuck.
        push_word(4'b0000);
        drain();
        ign = 1'b1;
        in_valid = 1'b1;
        in_data = 4'b0001;
        repeat (620) step();
        in_valid = 1'b0;
        drain();
        check("sat_cnt", 32'(err_cnt0), 32'd255);
        push_word(4'b0001);
        for (int i = 0; i < 10; i++) begin
            if (fq.size() > 0 && fq[0].drv + 2 == cyc + 1) break;
            step();
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_cnt", 32'(err_cnt0), 32'd1);
        check("clr_err", 32'(err0), 32'd1);
        drain();
        ign = 1'b0;
        push_word(4'b0000);
        drain();

        // Random traffic segments.
        for (int s = 0; s < 3; s++) begin
            ign = 1'($urandom % 2);
            for (int i = 0; i < 400; i++) begin
                in_valid = ($urandom % 3) != 0;
                in_data  = W'($urandom);
                clr_err  = ($urandom % 20) == 0;
                step();
            end
            in_valid = 1'b0;
            clr_err  = 1'b0;
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Drives a bank of WIDTH external JK flip-flops so that their outputs follow a queued sequence of target words. Each target word is accepted over a valid/ready handshake and buffered in a small FIFO. The block then computes the J/K excitation for every bit from the flip-flop feedback and the target, and pulses it for one cycle. One cycle later it checks the feedback against the target and records mismatches. It is the stimulus side of the JK flip-flop bank: the flip-flops turn J/K into Q, and this block turns a desired Q into J/K.

## Interface
- WIDTH, 4, number of flip-flops driven (1..32)
- DEPTH, 4, target FIFO entries (power of 2, >=2)
- TOGGLE_MODE, 0, 0: transitions use set/reset (J,K=10/01); 1: transitions use toggle (J,K=11)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  target word offered
- in_data  in  WIDTH  target word
- in_ready  out  1  FIFO not full; 0 while rst low
- q_fb  in  WIDTH  Q outputs of the external flip-flop bank (registered externally, same clk)
- clr_err  in  1  synchronous clear of err/err_cnt
- j  out  WIDTH  J inputs to flip-flop bank
- k  out  WIDTH  K inputs to flip-flop bank
- done  out  1  one-cycle pulse when a target has been checked
- match  out  1  valid with done: q_fb equalled target
- err  out  1  sticky: at least one mismatch since reset/clr_err
- err_cnt  out  8  mismatch count, saturates at 255
- busy  out  1  FSM not IDLE or FIFO not empty

## Operation
- FIFO: push on in_valid && in_ready. Pop on entry to DRIVE. in_ready = !full (combinational). When full, in_valid is ignored even in a cycle that also pops; push and pop in the same cycle are legal when not full. Pointers wrap modulo DEPTH, with an extra wrap bit distinguishing full from empty.
- Excitation per bit i, with q = q_fb[i] and t = target[i]:
  - q == t: J=0, K=0 (hold).
  - q=0, t=1: J=1, K=0, or J=K=1 if TOGGLE_MODE.
  - q=1, t=0: J=0, K=1, or J=K=1 if TOGGLE_MODE.
- FSM states:
  - IDLE: j=k=0. If FIFO is not empty, go to DRIVE: latch the head into target_reg, register j/k from q_fb and the head, and pop.
  - DRIVE: j/k hold the registered excitation for exactly this one cycle. Next edge: go to CHECK and clear j=k=0.
  - CHECK: at the edge, compare q_fb with target_reg. Pulse done for one cycle with match = (q_fb == target_reg). On mismatch, set err and increment err_cnt (saturating). Then, if the FIFO is not empty, go directly to DRIVE (latch and pop as from IDLE); otherwise go to IDLE.
- clr_err in the same cycle as a mismatch: the clear applies first, so err=1 and err_cnt=1 afterwards.
- match holds its last value between done pulses.

## Timing
- Reset (rst=0), applied immediately and asynchronously: FSM=IDLE, FIFO empty, j=0, k=0, done=0, match=0, err=0, err_cnt=0, busy=0, in_ready=0.
- A reset mid-operation discards queued entries and any in-flight check, and produces no done pulse.
- Latency, empty FIFO, word pushed at edge E0:
  - E1: enter DRIVE; j/k valid during E1..E2.
  - E2: the flip-flops update; j/k return to 0.
  - E3: comparison; done is high during E3..E4.
- Back-to-back throughput: one word per 2 cycles (DRIVE, CHECK, DRIVE, ...).
- j/k are registered outputs with no combinational path from q_fb.
- A target equal to the current q_fb still takes DRIVE (j=k=0) and CHECK, and produces done with match=1.

## Test plan
- Reset, then no input: j=k=0, busy=0, in_ready=1 and done=0 for 10 cycles. Assert rst low mid-DRIVE: j/k go to 0 immediately and no done pulse follows.
- WIDTH=4, TOGGLE_MODE=0, model bank at Q=0000. Push 1010:
  - DRIVE cycle shows j=1010, k=0000.
  - Push 0110 next: j=0100, k=1000.
  - Each produces done with match=1, and err stays 0.
- TOGGLE_MODE=1, Q=0011, push 0101: j=k=0110 for one cycle, then done with match=1.
- Mismatch: the model bank ignores bit 0. Push 0001 from Q=0000: done with match=0, err=1, err_cnt=1. Repeat 300 times: err_cnt saturates at 255. clr_err coincident with a further mismatch: err_cnt=1.
- FIFO full with DEPTH=4:
  - Hold in_valid high and block progress so no pop occurs: after 4 accepts in_ready=0 and the 5th word is not accepted.
  - Release: all 4 words are driven in order with done spaced every 2 cycles, and busy falls the cycle after the last CHECK.
- Hold target: push a word equal to the current Q: j=k=0 in DRIVE, then done with match=1.
